// File: rtl/sdram_capture_wr.sv
// sdram_capture_wr: captures an ADC stream into a circular SDRAM region with
// pre-trigger history, buffering samples locally and pacing writes so the
// controller's 8-deep write buffer (visible only through its empty flag)
// can never overflow.
module sdram_capture_wr #(
    parameter int P_DATA_NBIT = 16,
    parameter int P_ADDR_NBIT = 16,
    parameter int P_FIFO_AW   = 4,
    parameter int P_BURST     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm,
    input  logic                   trig,
    input  logic [P_ADDR_NBIT-1:0] post_len,
    input  logic [P_DATA_NBIT-1:0] adc_data,
    input  logic                   adc_dv,
    output logic                   wren,
    output logic [P_ADDR_NBIT-1:0] waddr,
    output logic [P_DATA_NBIT-1:0] wdata,
    input  logic                   wstatus,
    output logic                   busy,
    output logic                   done,
    output logic [P_ADDR_NBIT-1:0] trig_addr,
    output logic                   ovf
);

    localparam int LP_DEPTH     = 1 << P_FIFO_AW;
    localparam int LP_CRED_NBIT = $clog2(P_BURST + 1);

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_POST, S_FLUSH, S_DONE} state_t;
    typedef enum logic [1:0] {W_RUN, W_GUARD, W_WAIT} wstate_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    wstate_t                 r_wstate;
    wstate_t                 w_wstate_nxt;
    logic [LP_CRED_NBIT-1:0] r_credit;
    logic [LP_CRED_NBIT-1:0] w_credit_nxt;
    logic                    r_guard;
    logic                    w_guard_nxt;

    logic [P_DATA_NBIT-1:0]  r_mem [LP_DEPTH];
    logic [P_FIFO_AW-1:0]    r_rd_ptr;
    logic [P_FIFO_AW-1:0]    r_wr_ptr;
    logic [P_FIFO_AW:0]      r_count;

    logic [P_ADDR_NBIT-1:0]  r_post_len;
    logic [P_ADDR_NBIT-1:0]  r_post_cnt;
    logic [P_ADDR_NBIT-1:0]  r_in_addr;
    logic [P_ADDR_NBIT-1:0]  r_wr_addr;
    logic [P_ADDR_NBIT-1:0]  r_trig_addr;
    logic                    r_ovf;

    logic                    r_wren;
    logic [P_ADDR_NBIT-1:0]  r_waddr;
    logic [P_DATA_NBIT-1:0]  r_wdata;

    logic w_empty;
    logic w_full;
    logic w_accept;
    logic w_push;
    logic w_drop;
    logic w_pop;
    logic w_arm_go;
    logic w_post_last;
    logic w_flush_ok;

    // A full FIFO refuses a sample even when a pop happens in the same cycle.
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == (P_FIFO_AW + 1)'(LP_DEPTH));
    assign w_accept    = (r_state == S_ARMED) || (r_state == S_POST);
    assign w_push      = w_accept && adc_dv && !w_full;
    assign w_drop      = w_accept && adc_dv && w_full;
    assign w_pop       = (r_wstate == W_RUN) && !w_empty;
    assign w_arm_go    = (r_state == S_IDLE) && arm;
    assign w_post_last = ((r_post_cnt + P_ADDR_NBIT'(1)) == r_post_len);
    assign w_flush_ok  = w_empty && wstatus &&
                         (((r_wstate == W_RUN) && (r_credit == '0)) || (r_wstate == W_WAIT));

    // Main capture FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Main capture FSM next-state: arm and trig only count in their own states.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (arm) w_state_nxt = S_ARMED;
            S_ARMED: if (trig) w_state_nxt = (r_post_len == '0) ? S_FLUSH : S_POST;
            S_POST:  if (w_push && w_post_last) w_state_nxt = S_FLUSH;
            S_FLUSH: if (w_flush_ok) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Write pacing FSM registers: credit counts writes since the last drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate <= W_RUN;
            r_credit <= '0;
            r_guard  <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_credit <= w_credit_nxt;
            r_guard  <= w_guard_nxt;
        end
    end

    // Write pacing next-state; during flush a partial burst is also drained so
    // that done means every word has reached the controller's SDRAM side.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_credit_nxt = r_credit;
        w_guard_nxt  = r_guard;
        case (r_wstate)
            W_RUN: begin
                if (w_pop) begin
                    w_credit_nxt = r_credit + LP_CRED_NBIT'(1);
                    if (r_credit == LP_CRED_NBIT'(P_BURST - 1)) begin
                        w_wstate_nxt = W_GUARD;
                        w_guard_nxt  = 1'b0;
                    end
                end else if ((r_state == S_FLUSH) && (r_credit != '0)) begin
                    w_wstate_nxt = W_GUARD;
                    w_guard_nxt  = 1'b0;
                end
            end
            W_GUARD: begin
                if (r_guard) w_wstate_nxt = W_WAIT;
                else         w_guard_nxt  = 1'b1;
            end
            W_WAIT: begin
                if (wstatus) begin
                    w_wstate_nxt = W_RUN;
                    w_credit_nxt = '0;
                end
            end
            default: w_wstate_nxt = W_RUN;
        endcase
    end

    // Sample storage; contents need no reset because occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= adc_data;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + P_FIFO_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + P_FIFO_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (P_FIFO_AW + 1)'(1);
                2'b01:   r_count <= r_count - (P_FIFO_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Capture bookkeeping: ring input address, post-trigger count, trigger address, overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_post_len  <= '0;
            r_post_cnt  <= '0;
            r_in_addr   <= '0;
            r_trig_addr <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_arm_go) begin
                r_post_len <= post_len;
                r_post_cnt <= '0;
                r_in_addr  <= '0;
                r_ovf      <= 1'b0;
            end else begin
                if (w_push) r_in_addr <= r_in_addr + P_ADDR_NBIT'(1);
                if (w_drop) r_ovf <= 1'b1;
                if ((r_state == S_POST) && w_push) r_post_cnt <= r_post_cnt + P_ADDR_NBIT'(1);
            end
            if ((r_state == S_ARMED) && trig) r_trig_addr <= r_in_addr;
        end
    end

    // Registered write port; address and data hold their last values between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_addr <= '0;
            r_wren    <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
        end else begin
            if (w_arm_go)   r_wr_addr <= '0;
            else if (w_pop) r_wr_addr <= r_wr_addr + P_ADDR_NBIT'(1);
            if (w_pop) begin
                r_wren  <= 1'b1;
                r_waddr <= r_wr_addr;
                r_wdata <= r_mem[r_rd_ptr];
            end else begin
                r_wren  <= 1'b0;
            end
        end
    end

    assign wren      = r_wren;
    assign waddr     = r_waddr;
    assign wdata     = r_wdata;
    assign busy      = (r_state == S_ARMED) || (r_state == S_POST) || (r_state == S_FLUSH);
    assign done      = (r_state == S_DONE);
    assign trig_addr = r_trig_addr;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_sdram_capture_wr.sv
// Bench for sdram_capture_wr: a 16-bit-address and a 4-bit-address instance
// share one stimulus stream and are compared every cycle against a queue-based
// behavioural model, with directed scenarios pinned by literal expectations.
module tb_sdram_capture_wr;

    localparam int DEPTH = 16;
    localparam int BURST = 8;

    typedef enum {M_IDLE, M_ARMED, M_POST, M_FLUSH, M_DONE} mphase_t;
    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        trig = 1'b0;
    logic        adcDv = 1'b0;
    logic        wstatus = 1'b1;
    logic [15:0] postLen = 16'd0;
    logic [15:0] adcData = 16'd0;

    logic        wren16, busy16, done16, ovf16;
    logic [15:0] waddr16, wdata16, trigAddr16;
    logic        wren4, busy4, done4, ovf4;
    logic [3:0]  waddr4, trigAddr4;
    logic [15:0] wdata4;

    int vectors = 0;
    int miscompares = 0;
    int doneCnt = 0;
    int startDone;
    int n;
    entry_t log16[$];
    entry_t log4[$];

    // Model state
    mphase_t     mPhase;
    entry_t      fifoQ[$];
    logic [15:0] mInAddr, mTrigAddr, mWaddr, mWdata;
    int          mPostLen, mPostSeen, mSinceDrain, mHoldoff;
    bit          mWaitEmpty, mWren, mOvf;

    sdram_capture_wr #(.P_DATA_NBIT(16), .P_ADDR_NBIT(16), .P_FIFO_AW(4), .P_BURST(8)) u_dut16 (
        .clk(clk), .rst(rst), .arm(arm), .trig(trig), .post_len(postLen),
        .adc_data(adcData), .adc_dv(adcDv), .wren(wren16), .waddr(waddr16),
        .wdata(wdata16), .wstatus(wstatus), .busy(busy16), .done(done16),
        .trig_addr(trigAddr16), .ovf(ovf16)
    );

    sdram_capture_wr #(.P_DATA_NBIT(16), .P_ADDR_NBIT(4), .P_FIFO_AW(4), .P_BURST(8)) u_dut4 (
        .clk(clk), .rst(rst), .arm(arm), .trig(trig), .post_len(postLen[3:0]),
        .adc_data(adcData), .adc_dv(adcDv), .wren(wren4), .waddr(waddr4),
        .wdata(wdata4), .wstatus(wstatus), .busy(busy4), .done(done4),
        .trig_addr(trigAddr4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit a, input bit t, input bit dv, input logic [15:0] d, input bit ws);
        arm = a;
        trig = t;
        adcDv = dv;
        adcData = d;
        wstatus = ws;
        @(negedge clk);
    endtask

    task automatic waitDone(input string name, input int maxCycles, input bit dvOn);
        int start;
        int cnt;
        start = doneCnt;
        cnt = 0;
        while (doneCnt == start && cnt < maxCycles) begin
            applyStimulus(1'b0, 1'b0, dvOn, 16'($urandom), 1'b1);
            cnt++;
        end
        vectors++;
        if (doneCnt == start) begin
            miscompares++;
            $display("[TB] FAIL %s: done not seen within %0d cycles", name, maxCycles);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    endtask

    task automatic modelReset();
        mPhase = M_IDLE;
        fifoQ.delete();
        mInAddr = '0;
        mTrigAddr = '0;
        mWaddr = '0;
        mWdata = '0;
        mPostLen = 0;
        mPostSeen = 0;
        mSinceDrain = 0;
        mHoldoff = 0;
        mWaitEmpty = 1'b0;
        mWren = 1'b0;
        mOvf = 1'b0;
    endtask

    // One clock of the capture rules: writes leave the queue oldest first,
    // bursts of BURST are followed by two idle cycles and a wait for empty.
    task automatic modelStep();
        bit capture, canWrite, popNow, pushNow, dropNow, flushOk;
        logic [15:0] curIn;
        entry_t e;
        curIn    = mInAddr;
        capture  = (mPhase == M_ARMED) || (mPhase == M_POST);
        canWrite = (mHoldoff == 0) && !mWaitEmpty;
        popNow   = canWrite && (fifoQ.size() > 0);
        pushNow  = capture && adcDv && (fifoQ.size() < DEPTH);
        dropNow  = capture && adcDv && (fifoQ.size() == DEPTH);
        flushOk  = (fifoQ.size() == 0) && wstatus && ((canWrite && mSinceDrain == 0) || mWaitEmpty);

        mWren = popNow;
        if (popNow) begin
            e = fifoQ.pop_front();
            mWaddr = e.addr;
            mWdata = e.data;
        end

        if (mHoldoff > 0) begin
            mHoldoff--;
            if (mHoldoff == 0) mWaitEmpty = 1'b1;
        end else if (mWaitEmpty) begin
            if (wstatus) begin
                mWaitEmpty = 1'b0;
                mSinceDrain = 0;
            end
        end else if (popNow) begin
            mSinceDrain++;
            if (mSinceDrain == BURST) mHoldoff = 2;
        end else if (mPhase == M_FLUSH && fifoQ.size() == 0 && mSinceDrain != 0) begin
            mHoldoff = 2;
        end

        if (pushNow) begin
            e.addr = curIn;
            e.data = adcData;
            fifoQ.push_back(e);
            mInAddr = curIn + 16'd1;
        end
        if (dropNow) mOvf = 1'b1;

        case (mPhase)
            M_IDLE: if (arm) begin
                mPhase = M_ARMED;
                mPostLen = int'(postLen);
                mInAddr = '0;
                mOvf = 1'b0;
            end
            M_ARMED: if (trig) begin
                mTrigAddr = curIn;
                mPostSeen = 0;
                mPhase = (mPostLen == 0) ? M_FLUSH : M_POST;
            end
            M_POST: if (pushNow) begin
                mPostSeen++;
                if (mPostSeen == mPostLen) mPhase = M_FLUSH;
            end
            M_FLUSH: if (flushOk) mPhase = M_DONE;
            M_DONE: mPhase = M_IDLE;
            default: mPhase = M_IDLE;
        endcase
    endtask

    // Advance the behavioural model alongside the DUTs.
    always @(posedge clk or posedge rst) begin
        if (rst) modelReset();
        else     modelStep();
    end

    // Compare both instances against the model every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("wren16", wren16, mWren);
            checkOutput("waddr16", waddr16, mWaddr);
            checkOutput("wdata16", wdata16, mWdata);
            checkOutput("busy16", busy16, (mPhase == M_ARMED || mPhase == M_POST || mPhase == M_FLUSH));
            checkOutput("done16", done16, (mPhase == M_DONE));
            checkOutput("trig_addr16", trigAddr16, mTrigAddr);
            checkOutput("ovf16", ovf16, mOvf);
            checkOutput("wren4", wren4, mWren);
            checkOutput("waddr4", waddr4, mWaddr[3:0]);
            checkOutput("wdata4", wdata4, mWdata);
            checkOutput("busy4", busy4, (mPhase == M_ARMED || mPhase == M_POST || mPhase == M_FLUSH));
            checkOutput("done4", done4, (mPhase == M_DONE));
            checkOutput("trig_addr4", trigAddr4, mTrigAddr[3:0]);
            checkOutput("ovf4", ovf4, mOvf);
        end
    end

    // Record writes and done pulses shortly after each edge for the directed checks.
    always @(posedge clk) begin
        #1;
        if (wren16) log16.push_back('{waddr16, wdata16});
        if (wren4)  log4.push_back('{16'(waddr4), wdata4});
        if (done16) doneCnt++;
    end

    initial begin
        // Reset state
        #2;
        checkOutput("reset wren", wren16, 0);
        checkOutput("reset busy", busy16, 0);
        checkOutput("reset done", done16, 0);
        checkOutput("reset ovf", ovf16, 0);
        checkOutput("reset trig_addr", trigAddr16, 0);
        checkOutput("reset waddr4", waddr4, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Scenario A: 5 pre-trigger samples, trig with the 6th, 3 post samples
        $display("[TB] scenario A: basic capture");
        log16.delete();
        startDone = doneCnt;
        postLen = 16'd3;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 16'(i), 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'd6, 1'b1);
        for (int i = 7; i <= 9; i++) applyStimulus(1'b0, 1'b0, 1'b1, 16'(i), 1'b1);
        waitDone("A done", 100, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("A trig_addr", trigAddr16, 5);
        checkOutput("A wren count", log16.size(), 9);
        for (int i = 0; i < 9 && i < log16.size(); i++) begin
            checkOutput("A waddr", log16[i].addr, i);
            checkOutput("A wdata", log16[i].data, i + 1);
        end
        checkOutput("A done pulses", doneCnt - startDone, 1);

        // Scenario R: reset mid-POST with writes in flight
        $display("[TB] scenario R: reset during post-trigger");
        postLen = 16'd10;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 1'b1, 16'(16'h100 + i), 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h200, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h201, 1'b1);
        checkOutput("R trig_addr before reset", trigAddr16, 12);
        checkOutput("R wren before reset", wren16, 1);
        rst = 1'b1;
        #1;
        checkOutput("R wren in reset", wren16, 0);
        checkOutput("R busy in reset", busy16, 0);
        checkOutput("R done in reset", done16, 0);
        checkOutput("R ovf in reset", ovf16, 0);
        checkOutput("R trig_addr in reset", trigAddr16, 0);
        checkOutput("R trig_addr4 in reset", trigAddr4, 0);
        @(negedge clk);
        rst = 1'b0;
        log16.delete();
        postLen = 16'd1;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("R idle after reset", busy16, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hABCD, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hABCE, 1'b1);
        waitDone("R done", 100, 1'b0);
        checkOutput("R write count", log16.size(), 2);
        checkOutput("R first waddr", (log16.size() > 0) ? log16[0].addr : 16'hFFFF, 0);
        checkOutput("R first wdata", (log16.size() > 0) ? log16[0].data : 16'h0, 16'hABCD);

        // Scenario B: burst limit with stalled controller, then overflow
        $display("[TB] scenario B: burst pacing and overflow");
        log16.delete();
        postLen = 16'd4;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 1'b1, 16'(16'h300 + i), 1'b0);
        checkOutput("B wren count while stalled", log16.size(), 8);
        checkOutput("B ovf", ovf16, 1);
        n = 0;
        while (log16.size() == 8 && n < 10) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
            n++;
        end
        checkOutput("B resume addr", (log16.size() > 8) ? log16[8].addr : 16'hFFFF, 8);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h3FF, 1'b1);
        waitDone("B done", 300, 1'b1);
        checkOutput("B ovf sticky", ovf16, 1);

        // Scenario W: 4-bit address ring wrap
        $display("[TB] scenario W: address wrap");
        log4.delete();
        postLen = 16'd2;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b1, 16'(16'h500 + i), 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h514, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h515, 1'b1);
        waitDone("W done", 100, 1'b0);
        checkOutput("W trig_addr4", trigAddr4, 4);
        checkOutput("W trig_addr16", trigAddr16, 20);
        checkOutput("W write count", log4.size(), 22);
        checkOutput("W last waddr4", (log4.size() > 0) ? log4[$].addr : 16'hFFFF, 5);
        checkOutput("W last wdata4", (log4.size() > 0) ? log4[$].data : 16'h0, 16'h515);
        checkOutput("W ovf4", ovf4, 0);

        // Scenario Z: post_len of zero, arm/trig pulses while busy
        $display("[TB] scenario Z: zero post length");
        log16.delete();
        startDone = doneCnt;
        postLen = 16'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 16'(16'h600 + i), 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h6F0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h6F1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h6F2, 1'b0);
        checkOutput("Z busy while flushing", busy16, 1);
        waitDone("Z done", 100, 1'b0);
        checkOutput("Z write count", log16.size(), 6);
        checkOutput("Z trig_addr", trigAddr16, 6);
        checkOutput("Z done pulses", doneCnt - startDone, 1);
        checkOutput("Z idle after done", busy16, 0);

        // Randomized traffic checked by the model every cycle
        $display("[TB] randomized traffic");
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) postLen = 16'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 24) == 0, $urandom_range(0, 14) == 0,
                          $urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0);
        end
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
